// File: rtl/fdp_pkg.sv
// Shared types and constants for the fp16 dot-product sequencer.
// PAIR_W is the width of one packed {y,x} element pair.
package fdp_pkg;

    localparam int PAIR_W = 32;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD0,
        S_LOAD1,
        S_DRAIN,
        S_DONE
    } state_e;

endpackage

// File: rtl/fdp_dot_sequencer_if.sv
// Job, element-stream, MAC-operand and result bundle for the sequencer.
// master drives jobs and beats; slave is the sequencer itself.
interface fdp_dot_sequencer_if
    import fdp_pkg::*;
#(
    parameter int LEN_W = 8
);

    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic [PAIR_W-1:0] in_data;
    logic              in_ready;
    logic [PAIR_W-1:0] mac_rs1;
    logic [PAIR_W-1:0] mac_rs2;
    logic [PAIR_W-1:0] mac_rs3;
    logic [PAIR_W-1:0] mac_out;
    logic              res_valid;
    logic [31:0]       res_data;
    logic              res_ready;
    logic              busy;

    modport master (
        output start, len, in_valid, in_data,
        output mac_out, res_ready,
        input  in_ready, mac_rs1, mac_rs2, mac_rs3,
        input  res_valid, res_data, busy
    );

    modport slave (
        input  start, len, in_valid, in_data,
        input  mac_out, res_ready,
        output in_ready, mac_rs1, mac_rs2, mac_rs3,
        output res_valid, res_data, busy
    );

endinterface

// File: rtl/fdp_lat_pipe.sv
// Issue-flag shift register: top bit strobes the accumulator capture,
// lower bits flag an accumulate still in flight.
module fdp_lat_pipe #(
    parameter int MAC_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic issue_i,
    output logic cap_o,
    output logic pend_o
);

    logic [MAC_LAT:0] pipe_q;
    logic [MAC_LAT:0] pipe_d;

    assign pipe_d = {pipe_q[MAC_LAT-1:0], issue_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign cap_o  = pipe_q[MAC_LAT];
    assign pend_o = |pipe_q[MAC_LAT-1:0];

endmodule

// File: rtl/fdp_dot_sequencer.sv
// fp16 dot-product sequencer: packs element pairs into MAC operands.
// Define FDP_SEQ_ACC_INIT_EN to add the acc_init seed port.
module fdp_dot_sequencer
    import fdp_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic clk,
    input  logic rst,
`ifdef FDP_SEQ_ACC_INIT_EN
    input  logic [PAIR_W-1:0] acc_init,
`endif
    fdp_dot_sequencer_if.slave bus
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] TWO = LEN_W'(2);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [PAIR_W-1:0] stage_q, stage_d;
    logic [PAIR_W-1:0] rs1_q, rs1_d;
    logic [PAIR_W-1:0] rs2_q, rs2_d;
    logic [PAIR_W-1:0] acc_q, acc_d;
    logic [31:0]       res_q, res_d;
    logic [PAIR_W-1:0] acc_seed;
    logic              issue;
    logic              cap;
    logic              pend;
    logic              rdy;

`ifdef FDP_SEQ_ACC_INIT_EN
    assign acc_seed = acc_init;
`else
    assign acc_seed = FP32_ZERO;
`endif

    fdp_lat_pipe #(
        .MAC_LAT (MAC_LAT)
    ) u_lat_pipe (
        .clk     (clk),
        .rst     (rst),
        .issue_i (issue),
        .cap_o   (cap),
        .pend_o  (pend)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        stage_d = stage_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        acc_d   = cap ? bus.mac_out : acc_q;
        res_d   = res_q;
        issue   = 1'b0;
        rdy     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rem_d = bus.len;
                    acc_d = acc_seed;
                    if (bus.len == '0) begin
                        res_d   = acc_seed;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD0;
                    end
                end
            end
            S_LOAD0: begin
                // a padded issue must not overlap an accumulate still in flight
                rdy = (rem_q == ONE) ? !pend : 1'b1;
                if (bus.in_valid && rdy) begin
                    stage_d = bus.in_data;
                    if (rem_q == ONE) begin
                        rs1_d   = bus.in_data;
                        rs2_d   = {FP16_ZERO, FP16_ZERO};
                        issue   = 1'b1;
                        rem_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_LOAD1;
                    end
                end
            end
            S_LOAD1: begin
                rdy = !pend;
                if (bus.in_valid && rdy) begin
                    rs1_d   = stage_q;
                    rs2_d   = bus.in_data;
                    issue   = 1'b1;
                    rem_d   = rem_q - TWO;
                    state_d = (rem_q == TWO) ? S_DRAIN : S_LOAD0;
                end
            end
            S_DRAIN: begin
                if (!pend && !cap) begin
                    res_d   = bus.mac_out;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            stage_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            stage_q <= stage_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.mac_rs1   = rs1_q;
    assign bus.mac_rs2   = rs2_q;
    assign bus.mac_rs3   = acc_q;
    assign bus.res_data  = res_q;
    assign bus.res_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fdp_dot_sequencer.sv
// Directed bench for fdp_dot_sequencer with a one-register fp MAC model.
// Define FDP_SEQ_ACC_INIT_EN to also exercise the acc_init seed.
module tb_fdp_dot_sequencer;

    localparam int MAC_LAT = 1;

    typedef struct {
        string            name;
        logic [7:0]       len;
        logic [3:0][31:0] beats;
        int               gap;
        int               hold;
        bit               poke;
        logic [31:0]      exp_res;
        logic [31:0]      exp_rs2;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fdp_dot_sequencer_if #(.LEN_W(8)) bus ();

`ifdef FDP_SEQ_ACC_INIT_EN
    logic [31:0] acc_init;
    fdp_dot_sequencer #(
        .LEN_W   (8),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .acc_init (acc_init),
        .bus      (bus)
    );
`else
    fdp_dot_sequencer #(
        .LEN_W   (8),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    function automatic real h2r(input logic [15:0] h);
        logic [63:0] d;
        if (h[14:0] == 15'd0) return 0.0;
        d = {h[15], 11'(int'(h[14:10]) - 15 + 1023),
             h[9:0], 42'd0};
        return $bitstoreal(d);
    endfunction

    function automatic real s2r(input logic [31:0] s);
        logic [63:0] d;
        if (s[30:0] == 31'd0) return 0.0;
        d = {s[31], 11'(int'(s[30:23]) - 127 + 1023),
             s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127),
                d[51:29]};
    endfunction

    // MAC model: rs3 + x1*y1 + x2*y2, one output register
    always @(posedge clk) begin
        bus.mac_out <= r2s(s2r(bus.mac_rs3)
            + h2r(bus.mac_rs1[15:0]) * h2r(bus.mac_rs1[31:16])
            + h2r(bus.mac_rs2[15:0]) * h2r(bus.mac_rs2[31:16]));
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v);
        int n = 0;
        int gap = 0;
        int t = 0;
        int t_acc = -1;
        logic [31:0] r;
        bit stable;
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = v.len;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.res_valid && t < 300) begin
            bus.start = (v.poke && t == 3);
            bus.len   = v.poke ? 8'd7 : v.len;
            if (gap > 0) begin
                bus.in_valid = 1'b0;
                gap--;
            end else if (n < int'(v.len)) begin
                bus.in_valid = 1'b1;
                bus.in_data  = v.beats[n];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.in_valid && bus.in_ready) begin
                n++;
                gap   = v.gap;
                t_acc = t;
            end
            @(negedge clk);
            t++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        chk({v.name, "_valid"}, 32'(bus.res_valid), 32'd1);
        chk({v.name, "_beats"}, 32'(n), 32'(v.len));
        if (v.len == 8'd0)
            chk({v.name, "_lat"}, 32'(t), 32'd0);
        else
            chk({v.name, "_lat"}, 32'(t - t_acc - 1),
                32'(MAC_LAT + 2));
        chk({v.name, "_res"}, bus.res_data, v.exp_res);
        chk({v.name, "_rs3"}, bus.mac_rs3, v.exp_res);
        chk({v.name, "_rs2"}, bus.mac_rs2, v.exp_rs2);
        r = bus.res_data;
        stable = 1'b1;
        repeat (v.hold) begin
            @(negedge clk);
            if (!bus.res_valid || bus.res_data !== r)
                stable = 1'b0;
        end
        chk({v.name, "_hold"}, 32'(stable), 32'd1);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk({v.name, "_clr"}, 32'(bus.res_valid), 32'd0);
        chk({v.name, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    vec_t tbl[4];
    vec_t rj;

    initial begin
        tbl[0] = '{"len2", 8'd2,
            {32'h0, 32'h0, 32'h3C00_4200, 32'h4000_3C00},
            0, 0, 1'b0, 32'h40A0_0000, 32'h3C00_4200};
        tbl[1] = '{"len3", 8'd3,
            {32'h0, 32'h3C00_4200, 32'h4000_4000, 32'h3C00_3C00},
            0, 0, 1'b0, 32'h4100_0000, 32'h0000_0000};
        tbl[2] = '{"len0", 8'd0,
            {32'h0, 32'h0, 32'h0, 32'h0},
            0, 0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[3] = '{"gaps", 8'd4,
            {32'h3C00_3C00, 32'h3C00_3C00,
             32'h3C00_3C00, 32'h3C00_3C00},
            3, 5, 1'b1, 32'h4080_0000, 32'h3C00_3C00};
        rj = '{"post_rst", 8'd2,
            {32'h0, 32'h0, 32'h3C00_3C00, 32'h3C00_3C00},
            0, 2, 1'b0, 32'h4000_0000, 32'h3C00_3C00};

`ifdef FDP_SEQ_ACC_INIT_EN
        acc_init = 32'h0;
`endif
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_rs3", bus.mac_rs3, 32'h0);
        chk("rst_res", bus.res_data, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_job(tbl[i]);

        // reset between an issue and its capture
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 8'd2;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h4000_4000;
        #1 chk("mid_rdy0", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_data = 32'h4200_4200;
        #1 chk("mid_rdy1", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("mid_rs1", bus.mac_rs1, 32'h4000_4000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_busy", 32'(bus.busy), 32'd0);
        chk("mid_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_rs1z", bus.mac_rs1, 32'h0);
        chk("mid_rs2z", bus.mac_rs2, 32'h0);
        chk("mid_rs3z", bus.mac_rs3, 32'h0);
        chk("mid_resz", bus.res_data, 32'h0);
        repeat (3) @(negedge clk);
        chk("mid_stay", 32'(bus.mac_rs3), 32'h0);
        run_job(rj);

`ifdef FDP_SEQ_ACC_INIT_EN
        acc_init = 32'h3F80_0000;
        rj.name    = "seed2";
        rj.exp_res = 32'h4040_0000;
        run_job(rj);
        rj.name    = "seed0";
        rj.len     = 8'd0;
        rj.exp_res = 32'h3F80_0000;
        run_job(rj);
`endif

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
